// File: rtl/usb_tx_bit_encoder.sv
// rtl/usb_tx_bit_encoder.sv - USB full-speed TX bit stuffer, NRZI encoder and EOP generator
// Accepts bytes through a one-entry holding buffer and drives J/K/SE0 on bit_tick strobes.
module usb_tx_bit_encoder #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_STUFF_END, S_EOP1, S_EOP2, S_EOPJ, S_DONE
  } state_t;

  state_t state, state_nx;

  logic          hold_full;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_wr;
  logic          hold_take;

  logic [7:0]    shift_q, shift_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic          sh_last, sh_last_nx;
  logic [CW-1:0] ones_cnt, ones_nx;
  logic          line_j, line_j_nx;
  logic          dp_nx, dm_nx, active_nx, done_nx, err_nx;

  logic          do_bit;
  logic [7:0]    src_data;
  logic [2:0]    src_idx;
  logic          src_last;

  assign tx_data_ready = ~hold_full;
  assign hold_wr       = tx_data_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      shift_q   <= '0;
      bit_idx   <= '0;
      sh_last   <= 1'b0;
      ones_cnt  <= '0;
      line_j    <= 1'b1;
      d_plus    <= 1'b1;
      d_minus   <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_q   <= shift_nx;
      bit_idx   <= bit_idx_nx;
      sh_last   <= sh_last_nx;
      ones_cnt  <= ones_nx;
      line_j    <= line_j_nx;
      d_plus    <= dp_nx;
      d_minus   <= dm_nx;
      tx_active <= active_nx;
      tx_done   <= done_nx;
      tx_err    <= err_nx;
      // take and write are mutually exclusive: one needs full, the other empty
      if (hold_take) begin
        hold_full <= 1'b0;
      end else if (hold_wr) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift_q;
    bit_idx_nx = bit_idx;
    sh_last_nx = sh_last;
    ones_nx    = ones_cnt;
    line_j_nx  = line_j;
    dp_nx      = d_plus;
    dm_nx      = d_minus;
    active_nx  = tx_active;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    hold_take  = 1'b0;
    do_bit     = 1'b0;
    src_data   = shift_q;
    src_idx    = bit_idx;
    src_last   = sh_last;

    if (bit_tick) begin
      case (state)
        S_IDLE: begin
          if (hold_full) begin
            hold_take = 1'b1;
            active_nx = 1'b1;
            state_nx  = S_DATA;
            do_bit    = 1'b1;
            src_data  = hold_data;
            src_idx   = 3'd0;
            src_last  = hold_last;
          end
        end
        S_DATA: do_bit = 1'b1;
        S_STUFF_END: begin
          line_j_nx = ~line_j;
          ones_nx   = '0;
          dp_nx     = ~line_j;
          dm_nx     = line_j;
          state_nx  = S_EOP1;
        end
        S_EOP1: begin
          dp_nx    = 1'b0;
          dm_nx    = 1'b0;
          state_nx = S_EOP2;
        end
        S_EOP2: begin
          dp_nx    = 1'b0;
          dm_nx    = 1'b0;
          state_nx = S_EOPJ;
        end
        S_EOPJ: begin
          line_j_nx = 1'b1;
          ones_nx   = '0;
          dp_nx     = 1'b1;
          dm_nx     = 1'b0;
          state_nx  = S_DONE;
        end
        S_DONE: begin
          done_nx   = 1'b1;
          active_nx = 1'b0;
          state_nx  = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    if (do_bit) begin
      if (ones_cnt == STUFF_MAX) begin
        // stuffed zero: the data bit under the shifter waits for the next tick
        line_j_nx = ~line_j;
        ones_nx   = '0;
      end else begin
        if (src_data[0]) begin
          ones_nx = ones_cnt + 1'b1;
        end else begin
          ones_nx   = '0;
          line_j_nx = ~line_j;
        end
        shift_nx   = {1'b0, src_data[7:1]};
        bit_idx_nx = src_idx + 3'd1;
        sh_last_nx = src_last;
        if (src_idx == 3'd7) begin
          if (src_last && ones_nx == STUFF_MAX) begin
            state_nx = S_STUFF_END;
          end else if (src_last) begin
            state_nx = S_EOP1;
          end else if (hold_full) begin
            hold_take  = 1'b1;
            shift_nx   = hold_data;
            bit_idx_nx = 3'd0;
            sh_last_nx = hold_last;
          end else begin
            err_nx   = 1'b1;
            state_nx = S_EOP1;
          end
        end
      end
      dp_nx = line_j_nx;
      dm_nx = ~line_j_nx;
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
// tb/tb_usb_tx_bit_encoder.sv - directed self-checking bench for usb_tx_bit_encoder
module tb_usb_tx_bit_encoder;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_data_valid = 1'b0;
  logic       tx_data_ready, d_plus, d_minus, tx_active, tx_done, tx_err;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [1:0] s_line;
  logic       s_act, s_done, s_err, s_ready;

  always #5 clk = ~clk;

  usb_tx_bit_encoder #(.STUFF_LEN(6)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick),
    .tx_data(tx_data), .tx_last(tx_last), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .d_plus(d_plus), .d_minus(d_minus),
    .tx_active(tx_active), .tx_done(tx_done), .tx_err(tx_err)
  );

  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    s_line  = {d_plus, d_minus};
    s_act   = tx_active;
    s_done  = tx_done;
    s_err   = tx_err;
    s_ready = tx_data_ready;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    tx_data = d;
    tx_last = l;
    tx_data_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx_data_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    tx_data_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL put_byte %h: got ready=0 want ready=1 within 50 clks", d);
    else passes++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({d_plus, d_minus, tx_active, tx_done, tx_err, tx_data_ready} !== {J, 4'b0001})
      $display("FAIL reset_state: got %b want %b",
               {d_plus, d_minus, tx_active, tx_done, tx_err, tx_data_ready}, {J, 4'b0001});
    else passes++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({s_line, s_act} !== {J, 1'b0})
        $display("FAIL idle_tick[%0d]: got %b want %b", i, {s_line, s_act}, {J, 1'b0});
      else passes++;
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp [11];
    int d0, e0;
    exp = '{K, J, K, J, K, J, K, K, S, S, J};
    do_reset();
    d0 = done_cnt; e0 = err_cnt;
    put_byte(8'h80, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if ({s_line, s_act, s_done} !== {exp[i], 2'b10})
        $display("FAIL sync[%0d] line/act/done: got %b want %b", i, {s_line, s_act, s_done}, {exp[i], 2'b10});
      else passes++;
    end
    tick();
    checks++;
    if ({s_line, s_act, s_done} !== {J, 2'b01})
      $display("FAIL sync_end line/act/done: got %b want %b", {s_line, s_act, s_done}, {J, 2'b01});
    else passes++;
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0)
      $display("FAIL sync_counts: got done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0);
    else passes++;
  endtask

  task automatic test_all_ones();
    logic [1:0] exp [12];
    int e0;
    exp = '{J, J, J, J, J, J, K, K, K, S, S, J};
    do_reset();
    e0 = err_cnt;
    put_byte(8'hFF, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (s_line !== exp[i]) $display("FAIL ff[%0d] line: got %b want %b", i, s_line, exp[i]);
      else passes++;
    end
    tick();
    checks++;
    if ({s_act, s_done, err_cnt - e0} !== {2'b01, 32'd0})
      $display("FAIL ff_end act/done/err: got %b %b %0d want 0 1 0", s_act, s_done, err_cnt - e0);
    else passes++;
  endtask

  task automatic test_stuff_before_eop();
    logic [1:0] exp [12];
    exp = '{K, J, J, J, J, J, J, J, K, S, S, J};
    do_reset();
    put_byte(8'hFC, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (s_line !== exp[i]) $display("FAIL fc[%0d] line: got %b want %b", i, s_line, exp[i]);
      else passes++;
    end
    tick();
    checks++;
    if ({s_act, s_done} !== 2'b01)
      $display("FAIL fc_end act/done: got %b want 01", {s_act, s_done});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp [20];
    exp = '{K, J, K, J, J, J, J, J, J, J, K, K, K, J, K, J, K, S, S, J};
    do_reset();
    put_byte(8'hF0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (s_line !== exp[i]) $display("FAIL b2b[%0d] line: got %b want %b", i, s_line, exp[i]);
      else passes++;
      if (i == 0) put_byte(8'h0F, 1'b1);
    end
    tick();
    checks++;
    if ({s_act, s_done, s_err} !== 3'b010)
      $display("FAIL b2b_end act/done/err: got %b want 010", {s_act, s_done, s_err});
    else passes++;
  endtask

  task automatic test_underrun();
    logic [1:0] exp [11];
    int d0, e0;
    exp = '{J, K, K, J, J, K, K, J, S, S, J};
    do_reset();
    d0 = done_cnt; e0 = err_cnt;
    put_byte(8'h55, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if ({s_line, s_err, s_ready} !== {exp[i], (i == 7), 1'b1})
        $display("FAIL underrun[%0d] line/err/ready: got %b want %b", i,
                 {s_line, s_err, s_ready}, {exp[i], (i == 7), 1'b1});
      else passes++;
    end
    tick();
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 1 || tx_active !== 1'b0)
      $display("FAIL underrun_counts: got done=%0d err=%0d act=%b want 1 1 0",
               done_cnt - d0, err_cnt - e0, tx_active);
    else passes++;
  endtask

  task automatic test_reset_mid_packet();
    logic [1:0] exp [12];
    int d0;
    exp = '{J, J, J, J, J, J, K, K, K, S, S, J};
    do_reset();
    d0 = done_cnt;
    put_byte(8'hFF, 1'b0);
    tick();
    put_byte(8'hAA, 1'b1);
    for (int i = 1; i < 4; i++) tick();
    checks++;
    if ({s_line, s_act, s_ready} !== {J, 2'b10})
      $display("FAIL mid_before_rst line/act/ready: got %b want %b", {s_line, s_act, s_ready}, {J, 2'b10});
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({d_plus, d_minus, tx_active, tx_done, tx_data_ready} !== {J, 3'b001})
      $display("FAIL mid_after_rst line/act/done/ready: got %b want %b",
               {d_plus, d_minus, tx_active, tx_done, tx_data_ready}, {J, 3'b001});
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 0) $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0);
    else passes++;
    put_byte(8'hFF, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (s_line !== exp[i]) $display("FAIL mid_restart[%0d] line: got %b want %b", i, s_line, exp[i]);
      else passes++;
    end
    tick();
    checks++;
    if ({s_act, s_done} !== 2'b01)
      $display("FAIL mid_restart_end act/done: got %b want 01", {s_act, s_done});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sync();
    test_all_ones();
    test_stuff_before_eop();
    test_back_to_back();
    test_underrun();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
